// File: rtl/audio_frame_fifo.sv
// Elastic frame buffer between the SID audio producer and the I2S DSP-mode serialiser.
// Frames enter via valid/ready and leave one per frame_tick once the buffer has prefilled.
module audio_frame_fifo #(
    parameter int CH_BITS  = 16,
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 8,
    parameter int UCNT_W   = 16,
    localparam int BITS    = CH_BITS * CHANNELS,
    localparam int LVLW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [BITS-1:0]   s_data,
    input  logic              frame_tick,
    output logic [BITS-1:0]   audio_o,
    output logic [LVLW-1:0]   level,
    output logic              running,
    output logic [UCNT_W-1:0] underrun_cnt
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [BITS-1:0]   mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVLW-1:0]   level_q, level_d;
    logic [0:0]        state_q, state_d;
    logic [BITS-1:0]   audio_q, audio_d;
    logic [UCNT_W-1:0] ucnt_q, ucnt_d;
    logic              push;
    logic              pop;
    logic              underrun;

    // Valid/ready: a frame transfers on any clk edge where s_valid and s_ready are both high;
    // s_ready depends only on the stored level, so a same-cycle pop never frees a slot.
    assign s_ready = (level_q != LVLW'(DEPTH));
    assign push    = s_valid & s_ready;

    always_comb begin
        pop      = 1'b0;
        underrun = 1'b0;
        state_d  = state_q;
        audio_d  = audio_q;
        ucnt_d   = ucnt_q;
        case (state_q)
            ST_RUN: begin
                if (frame_tick) begin
                    if (level_q != '0) begin
                        pop = 1'b1;
                    end else begin
                        underrun = 1'b1;
                        state_d  = ST_FILL;
                    end
                end
            end
            default: begin
                if (level_q >= LVLW'(DEPTH / 2)) begin
                    state_d = ST_RUN;
                end
            end
        endcase

        if (pop) begin
            audio_d = mem_q[rd_ptr_q];
        end
        // Counter sticks at all-ones so a long dropout still reads as "many".
        if (underrun && (ucnt_q != '1)) begin
            ucnt_d = ucnt_q + UCNT_W'(1);
        end

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        case ({push, pop})
            2'b10:   level_d = level_q + LVLW'(1);
            2'b01:   level_d = level_q - LVLW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            state_q  <= ST_FILL;
            audio_q  <= '0;
            ucnt_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            state_q  <= state_d;
            audio_q  <= audio_d;
            ucnt_q   <= ucnt_d;
        end
    end

    // Storage needs no reset: clearing the pointers and level discards its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    assign audio_o      = audio_q;
    assign level        = level_q;
    assign running      = (state_q == ST_RUN);
    assign underrun_cnt = ucnt_q;

endmodule

// File: tb/tb_audio_frame_fifo.sv
// Bench for audio_frame_fifo: directed scenarios plus random traffic, checked every cycle
// against a queue-based model; a narrow-counter instance exercises counter saturation.
module tb_audio_frame_fifo;

    localparam int DEPTH = 8;
    localparam int BITS  = 64;
    localparam int LVLW  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            s_valid;
    logic [BITS-1:0] s_data;
    logic            frame_tick;
    logic            s_ready, s_ready_n;
    logic [BITS-1:0] audio_o, audio_n;
    logic [LVLW-1:0] level, level_n;
    logic            running, running_n;
    logic [15:0]     underrun_cnt;
    logic [3:0]      underrun_cnt_n;

    int checks = 0;
    int errors = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    audio_frame_fifo dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .frame_tick(frame_tick), .audio_o(audio_o), .level(level), .running(running),
        .underrun_cnt(underrun_cnt)
    );

    audio_frame_fifo #(.UCNT_W(4)) dut_n (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_n), .s_data(s_data),
        .frame_tick(frame_tick), .audio_o(audio_n), .level(level_n), .running(running_n),
        .underrun_cnt(underrun_cnt_n)
    );

    // ---------------- reference model ----------------
    logic [BITS-1:0] mq[$];
    bit              m_run;
    logic [BITS-1:0] m_audio;
    int unsigned     m_under;
    int              m_lvl;
    bit              m_rdy;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_run   = 1'b0;
            m_audio = '0;
            m_under = 0;
        end else begin
            m_lvl = mq.size();
            m_rdy = (m_lvl != DEPTH);
            if (m_run) begin
                if (frame_tick) begin
                    if (m_lvl > 0) m_audio = mq.pop_front();
                    else begin
                        m_under++;
                        m_run = 1'b0;
                    end
                end
            end else if (m_lvl >= DEPTH / 2) begin
                m_run = 1'b1;
            end
            if (s_valid && m_rdy) mq.push_back(s_data);
        end
    end

    function automatic logic [15:0] exp_ucnt16();
        return (m_under > 65535) ? 16'hFFFF : 16'(m_under);
    endfunction

    function automatic logic [3:0] exp_ucnt4();
        return (m_under > 15) ? 4'hF : 4'(m_under);
    endfunction

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [BITS-1:0] act, input logic [BITS-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("cmp_s_ready", 64'(s_ready), 64'(mq.size() != DEPTH));
            chk("cmp_level", 64'(level), 64'(mq.size()));
            chk("cmp_running", 64'(running), 64'(m_run));
            chk("cmp_audio", audio_o, m_audio);
            chk("cmp_ucnt", 64'(underrun_cnt), 64'(exp_ucnt16()));
            chk("cmp_ucnt_narrow", 64'(underrun_cnt_n), 64'(exp_ucnt4()));
            chk("cmp_audio_narrow", audio_n, m_audio);
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [BITS-1:0] frame(input int k);
        logic [15:0] s;
        s = 16'(k) * 16'h1111;
        return {s, s, s, s};
    endfunction

    task automatic cycle(input logic v, input logic [BITS-1:0] d, input logic t);
        s_valid    = v;
        s_data     = d;
        frame_tick = t;
        @(posedge clk);
        #1;
        s_valid    = 1'b0;
        frame_tick = 1'b0;
    endtask

    task automatic push(input logic [BITS-1:0] d);
        cycle(1'b1, d, 1'b0);
    endtask

    task automatic tick();
        cycle(1'b0, '0, 1'b1);
    endtask

    task automatic idle();
        cycle(1'b0, '0, 1'b0);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_audio"}, audio_o, 64'h0);
        chk({tag, "_level"}, 64'(level), 64'h0);
        chk({tag, "_running"}, 64'(running), 64'h0);
        chk({tag, "_ucnt"}, 64'(underrun_cnt), 64'h0);
        chk({tag, "_s_ready"}, 64'(s_ready), 64'h1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; frame_tick = 1'b0;
        #1;
        chk_reset_values("reset");
        #11 rst = 1'b0;

        // Prefill: ticks in FILL do nothing; fourth frame triggers RUN one edge later.
        for (int k = 1; k <= 3; k++) push(frame(k));
        tick(); tick();
        chk("fill_level", 64'(level), 64'd3);
        chk("fill_running", 64'(running), 64'd0);
        chk("fill_audio", audio_o, 64'h0);
        push(frame(4));
        chk("fill_4th_running", 64'(running), 64'd0);
        idle();
        chk("run_entered", 64'(running), 64'd1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("drain_order", audio_o, frame(k));
        end
        chk("drain_level", 64'(level), 64'd0);

        // Underrun, then refill to resume.
        tick();
        chk("underrun_hold", audio_o, 64'h4444_4444_4444_4444);
        chk("underrun_cnt1", 64'(underrun_cnt), 64'd1);
        chk("underrun_fill", 64'(running), 64'd0);
        for (int k = 5; k <= 8; k++) push(frame(k));
        idle();
        chk("run_resumed", 64'(running), 64'd1);
        for (int k = 5; k <= 8; k++) tick();

        // Fill to full, extra frame dropped, then ordered playout.
        for (int k = 1; k <= 8; k++) push(frame(k));
        chk("full_s_ready", 64'(s_ready), 64'd0);
        push(frame(9));
        chk("full_drop_level", 64'(level), 64'd8);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("full_order", audio_o, frame(k));
        end

        // Simultaneous push and pop at level 5, 8 and 0.
        for (int k = 1; k <= 5; k++) push(frame(k));
        cycle(1'b1, frame(6), 1'b1);
        chk("pp5_level", 64'(level), 64'd5);
        chk("pp5_audio", audio_o, frame(1));
        for (int k = 7; k <= 9; k++) push(frame(k));
        cycle(1'b1, frame(10), 1'b1);
        chk("pp8_level", 64'(level), 64'd7);
        chk("pp8_audio", audio_o, frame(2));
        for (int k = 0; k < 7; k++) tick();
        chk("pp8_tail", audio_o, frame(9));
        cycle(1'b1, frame(11), 1'b1);
        chk("pp0_level", 64'(level), 64'd1);
        chk("pp0_running", 64'(running), 64'd0);
        chk("pp0_ucnt", 64'(underrun_cnt), 64'd2);
        chk("pp0_audio", audio_o, frame(9));

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 99) < 60), {$urandom, $urandom}, 1'($urandom_range(0, 3) == 0));
        end

        // Asynchronous reset mid-stream in RUN with 6 frames stored.
        #2 rst = 1'b1;
        #3 rst = 1'b0;
        for (int k = 1; k <= 6; k++) push(frame(k));
        idle();
        chk("pre_async_running", 64'(running), 64'd1);
        chk("pre_async_level", 64'(level), 64'd6);
        tick();
        #2 rst = 1'b1;
        #1;
        chk_reset_values("async");
        #2 rst = 1'b0;
        for (int k = 12; k <= 15; k++) push(frame(k));
        idle();
        tick();
        chk("post_reset_first", audio_o, frame(12));

        // Repeated underruns saturate the narrow counter.
        tick(); tick(); tick(); tick();
        for (int r = 0; r < 20; r++) begin
            for (int k = 1; k <= 4; k++) push(frame(k));
            idle();
            for (int k = 0; k < 5; k++) tick();
        end
        chk("sat_narrow", 64'(underrun_cnt_n), 64'hF);
        chk("sat_wide_count", 64'(underrun_cnt), 64'd21);

        idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
